// File: rtl/mc_controller.sv
// Multicycle MIPS sequencing FSM: walks the shared-memory datapath one step per
// state, stalls on memory wait states, traps on illegal opcodes, counts retirements.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             a_lez_i,
  input  logic             mem_ready_i,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_srca,
  output logic [1:0]       alu_srcb,
  output logic [1:0]       ext_op,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_AWB   = 4'd7,
    S_BRANCH = 4'd8,  S_IEX    = 4'd9,  S_JUMP   = 4'd10, S_JAL   = 4'd11,
    S_JR     = 4'd12, S_LUI    = 4'd13, S_TRAP   = 4'd15
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_XOR = 4'b0011, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111,
                         ALU_NOR = 4'b1100;

  state_t           state_q, state_d;
  logic             dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q;
  logic             r_legal;
  logic [3:0]       alu_r, alu_i;

  always_comb begin
    r_legal = 1'b1;
    alu_r   = ALU_ADD;
    case (funct_i)
      6'b100000, 6'b100001: alu_r = ALU_ADD;
      6'b100010, 6'b100011: alu_r = ALU_SUB;
      6'b100100:            alu_r = ALU_AND;
      6'b100101:            alu_r = ALU_OR;
      6'b100110:            alu_r = ALU_XOR;
      6'b100111:            alu_r = ALU_NOR;
      6'b101010:            alu_r = ALU_SLT;
      default:              r_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_i = ALU_ADD;
    case (op_i)
      6'b001010: alu_i = ALU_SLT;
      6'b001100: alu_i = ALU_AND;
      6'b001101: alu_i = ALU_OR;
      6'b001110: alu_i = ALU_XOR;
      default:   alu_i = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          6'b000000: begin
            if (funct_i == 6'b001000) state_d = S_JR;
            else if (r_legal)         state_d = S_REX;
            else                      state_d = S_TRAP;
          end
          6'b100011, 6'b101011:                       state_d = S_MEMADR;
          6'b000100, 6'b000101, 6'b000110, 6'b000111: state_d = S_BRANCH;
          6'b001000, 6'b001001, 6'b001010,
          6'b001100, 6'b001101, 6'b001110:            state_d = S_IEX;
          6'b001111:                                  state_d = S_LUI;
          6'b000010:                                  state_d = S_JUMP;
          6'b000011:                                  state_d = S_JAL;
          default:                                    state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op_i == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
      S_REX:    begin state_d = S_AWB; dst_d = 1'b1; end
      S_IEX:    begin state_d = S_AWB; dst_d = 1'b0; end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      dst_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      if (state_d == S_FETCH && state_q != S_FETCH) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  logic mem_req_c, mem_write_c, ir_write_c, pc_en_c, reg_write_c;

  always_comb begin
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_en_c     = 1'b0;
    reg_write_c = 1'b0;
    iord        = 1'b0;
    pc_src      = 2'd0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    alu_srca    = 1'b0;
    alu_srcb    = 2'd0;
    ext_op      = 2'd0;
    alu_op      = ALU_AND;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_srcb   = 2'd1;
        alu_op     = ALU_ADD;
        ir_write_c = mem_ready_i;
        pc_en_c    = mem_ready_i;
      end
      S_DECODE: begin
        alu_srcb = 2'd3;
        alu_op   = ALU_ADD;
      end
      S_MEMADR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'd2;
        alu_op   = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 2'd1;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        iord        = 1'b1;
      end
      S_REX: begin
        alu_srca = 1'b1;
        alu_op   = alu_r;
      end
      S_AWB: begin
        reg_write_c = 1'b1;
        reg_dst     = {1'b0, dst_q};
      end
      S_BRANCH: begin
        alu_srca = 1'b1;
        alu_op   = ALU_SUB;
        pc_src   = 2'd1;
        pc_en_c  = ((op_i == 6'b000100) &  zero_i)  | ((op_i == 6'b000101) & ~zero_i) |
                   ((op_i == 6'b000110) &  a_lez_i) | ((op_i == 6'b000111) & ~a_lez_i);
      end
      S_IEX: begin
        alu_srca = 1'b1;
        alu_srcb = 2'd2;
        alu_op   = alu_i;
        ext_op   = (op_i[5:2] == 4'b0011) ? 2'd1 : 2'd0;
      end
      S_JUMP: begin
        pc_en_c = 1'b1;
        pc_src  = 2'd2;
      end
      S_JAL: begin
        pc_en_c     = 1'b1;
        pc_src      = 2'd2;
        reg_write_c = 1'b1;
        reg_dst     = 2'd2;
        mem_to_reg  = 2'd2;
      end
      S_JR: begin
        pc_en_c = 1'b1;
        pc_src  = 2'd3;
      end
      S_LUI: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 2'd3;
        ext_op      = 2'd2;
      end
      default: ;
    endcase
  end

  // Strobes drop combinationally with rst so an in-flight access dies immediately.
  assign mem_req   = mem_req_c   & ~rst;
  assign mem_write = mem_write_c & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign pc_en     = pc_en_c     & ~rst;
  assign reg_write = reg_write_c & ~rst;

  assign illegal   = (state_q == S_TRAP);
  assign state_o   = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: an instruction table run with zero wait
// states plus hand sequences for wait states, trap and reset mid-store.
module tb_mc_controller;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       op_i, funct_i;
  logic             zero_i, a_lez_i, mem_ready_i;
  logic             mem_req, mem_write, iord, ir_write, pc_en, reg_write;
  logic [1:0]       pc_src, reg_dst, mem_to_reg, alu_srcb, ext_op;
  logic             alu_srca, illegal;
  logic [3:0]       alu_op, state_o;
  logic [CNT_W-1:0] instr_cnt;

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
    .a_lez_i(a_lez_i), .mem_ready_i(mem_ready_i), .mem_req(mem_req),
    .mem_write(mem_write), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .ext_op(ext_op), .alu_op(alu_op), .illegal(illegal), .state_o(state_o),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  logic [21:0] ctl;
  assign ctl = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, reg_write,
                reg_dst, mem_to_reg, alu_srca, alu_srcb, ext_op, alu_op};

  int total = 0;
  int bad   = 0;

  function automatic logic [21:0] cw(input logic mreq, input logic mwr, input logic io,
                                     input logic irw, input logic pce, input logic [1:0] pcs,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                     input logic sa, input logic [1:0] sb, input logic [1:0] ex,
                                     input logic [3:0] alu);
    return {mreq, mwr, io, irw, pce, pcs, rw, rd, m2r, sa, sb, ex, alu};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        alez;
    int          cyc;
    logic [3:0]  s2;
    logic [21:0] c2;
    logic [3:0]  s3;
    logic [21:0] c3;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl[NV];

  // Starts with state FETCH just after a posedge; runs one instruction with no waits.
  task automatic run_instr(input int idx, input vec_t v);
    int          cyc;
    logic [3:0]  s2, s3;
    logic [21:0] c2, c3;
    logic [CNT_W-1:0] cnt0;
    op_i = v.op; funct_i = v.funct; zero_i = v.zero; a_lez_i = v.alez; mem_ready_i = 1'b1;
    cnt0 = instr_cnt;
    cyc = 0; s2 = '0; s3 = '0; c2 = '0; c3 = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) begin s2 = state_o; c2 = ctl; end
      if (k == 3) begin s3 = state_o; c3 = ctl; end
      @(posedge clk); #1;
      cyc++;
      if (state_o == 4'd0) break;
    end
    chk($sformatf("v%0d cycles", idx), 64'(cyc), 64'(v.cyc));
    chk($sformatf("v%0d exec state", idx), 64'(s2), 64'(v.s2));
    chk($sformatf("v%0d exec ctl", idx), 64'(c2), 64'(v.c2));
    if (v.cyc >= 4) begin
      chk($sformatf("v%0d 2nd state", idx), 64'(s3), 64'(v.s3));
      chk($sformatf("v%0d 2nd ctl", idx), 64'(c3), 64'(v.c3));
    end
    chk($sformatf("v%0d instr_cnt", idx), 64'(instr_cnt), 64'(cnt0 + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] madr, awb1, awb0, fetch_w;
    logic [CNT_W-1:0] cnt0;
    int rw_cnt;
    int exp_st[8];

    madr    = cw(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,2'd0,4'b0010);
    awb1    = cw(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0,2'd0,4'b0000);
    awb0    = cw(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd0,2'd0,4'b0000);
    fetch_w = cw(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd1,2'd0,4'b0010);

    tbl[0]  = '{6'h00, 6'h20, 0, 0, 4, 4'd6,  cw(0,0,0,0,0,0,0,0,0,1,0,0,4'b0010), 4'd7, awb1};
    tbl[1]  = '{6'h00, 6'h22, 0, 0, 4, 4'd6,  cw(0,0,0,0,0,0,0,0,0,1,0,0,4'b0110), 4'd7, awb1};
    tbl[2]  = '{6'h00, 6'h24, 0, 0, 4, 4'd6,  cw(0,0,0,0,0,0,0,0,0,1,0,0,4'b0000), 4'd7, awb1};
    tbl[3]  = '{6'h00, 6'h25, 0, 0, 4, 4'd6,  cw(0,0,0,0,0,0,0,0,0,1,0,0,4'b0001), 4'd7, awb1};
    tbl[4]  = '{6'h00, 6'h26, 0, 0, 4, 4'd6,  cw(0,0,0,0,0,0,0,0,0,1,0,0,4'b0011), 4'd7, awb1};
    tbl[5]  = '{6'h00, 6'h27, 0, 0, 4, 4'd6,  cw(0,0,0,0,0,0,0,0,0,1,0,0,4'b1100), 4'd7, awb1};
    tbl[6]  = '{6'h00, 6'h2a, 0, 0, 4, 4'd6,  cw(0,0,0,0,0,0,0,0,0,1,0,0,4'b0111), 4'd7, awb1};
    tbl[7]  = '{6'h00, 6'h23, 0, 0, 4, 4'd6,  cw(0,0,0,0,0,0,0,0,0,1,0,0,4'b0110), 4'd7, awb1};
    tbl[8]  = '{6'h08, 6'h00, 0, 0, 4, 4'd9,  cw(0,0,0,0,0,0,0,0,0,1,2,0,4'b0010), 4'd7, awb0};
    tbl[9]  = '{6'h0a, 6'h00, 0, 0, 4, 4'd9,  cw(0,0,0,0,0,0,0,0,0,1,2,0,4'b0111), 4'd7, awb0};
    tbl[10] = '{6'h0c, 6'h00, 0, 0, 4, 4'd9,  cw(0,0,0,0,0,0,0,0,0,1,2,1,4'b0000), 4'd7, awb0};
    tbl[11] = '{6'h0d, 6'h00, 0, 0, 4, 4'd9,  cw(0,0,0,0,0,0,0,0,0,1,2,1,4'b0001), 4'd7, awb0};
    tbl[12] = '{6'h0e, 6'h00, 0, 0, 4, 4'd9,  cw(0,0,0,0,0,0,0,0,0,1,2,1,4'b0011), 4'd7, awb0};
    tbl[13] = '{6'h04, 6'h00, 1, 0, 3, 4'd8,  cw(0,0,0,0,1,1,0,0,0,1,0,0,4'b0110), 4'd0, 22'd0};
    tbl[14] = '{6'h04, 6'h00, 0, 0, 3, 4'd8,  cw(0,0,0,0,0,1,0,0,0,1,0,0,4'b0110), 4'd0, 22'd0};
    tbl[15] = '{6'h05, 6'h00, 0, 0, 3, 4'd8,  cw(0,0,0,0,1,1,0,0,0,1,0,0,4'b0110), 4'd0, 22'd0};
    tbl[16] = '{6'h05, 6'h00, 1, 0, 3, 4'd8,  cw(0,0,0,0,0,1,0,0,0,1,0,0,4'b0110), 4'd0, 22'd0};
    tbl[17] = '{6'h06, 6'h00, 0, 1, 3, 4'd8,  cw(0,0,0,0,1,1,0,0,0,1,0,0,4'b0110), 4'd0, 22'd0};
    tbl[18] = '{6'h07, 6'h00, 0, 0, 3, 4'd8,  cw(0,0,0,0,1,1,0,0,0,1,0,0,4'b0110), 4'd0, 22'd0};
    tbl[19] = '{6'h07, 6'h00, 0, 1, 3, 4'd8,  cw(0,0,0,0,0,1,0,0,0,1,0,0,4'b0110), 4'd0, 22'd0};
    tbl[20] = '{6'h02, 6'h00, 0, 0, 3, 4'd10, cw(0,0,0,0,1,2,0,0,0,0,0,0,4'b0000), 4'd0, 22'd0};
    tbl[21] = '{6'h03, 6'h00, 0, 0, 3, 4'd11, cw(0,0,0,0,1,2,1,2,2,0,0,0,4'b0000), 4'd0, 22'd0};
    tbl[22] = '{6'h00, 6'h08, 0, 0, 3, 4'd12, cw(0,0,0,0,1,3,0,0,0,0,0,0,4'b0000), 4'd0, 22'd0};
    tbl[23] = '{6'h0f, 6'h00, 0, 0, 3, 4'd13, cw(0,0,0,0,0,0,1,0,3,0,0,2,4'b0000), 4'd0, 22'd0};
    tbl[24] = '{6'h23, 6'h00, 0, 0, 5, 4'd2,  madr, 4'd3, cw(1,0,1,0,0,0,0,0,0,0,0,0,4'b0000)};
    tbl[25] = '{6'h2b, 6'h00, 0, 0, 4, 4'd2,  madr, 4'd5, cw(1,1,1,0,0,0,0,0,0,0,0,0,4'b0000)};

    // Reset state, strobes gated during reset even with FETCH decoded.
    rst = 1'b1; op_i = '0; funct_i = '0; zero_i = 0; a_lez_i = 0; mem_ready_i = 1'b1;
    #2;
    chk("reset state", 64'(state_o), 64'd0);
    chk("reset cnt", 64'(instr_cnt), 64'd0);
    chk("reset illegal", 64'(illegal), 64'd0);
    chk("reset strobes", 64'({mem_req, mem_write, ir_write, pc_en, reg_write}), 64'd0);
    @(negedge clk); mem_ready_i = 1'b0; rst = 1'b0; #1;
    chk("fetch ctl wait", 64'(ctl), 64'(fetch_w));
    @(posedge clk); #1;
    chk("fetch hold", 64'(state_o), 64'd0);
    mem_ready_i = 1'b1; #1;
    chk("fetch ready ctl", 64'(ctl), 64'(cw(1,0,0,1,1,0,0,0,0,0,1,0,4'b0010)));

    // lw with two wait cycles in MEMRD; ready high in DECODE/MEMADR is ignored.
    exp_st = '{0, 1, 2, 3, 3, 3, 4, 0};
    op_i = 6'h23; funct_i = '0; cnt0 = instr_cnt; rw_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      mem_ready_i = (k <= 2 || k == 5);
      @(negedge clk);
      chk($sformatf("lw state k%0d", k), 64'(state_o), 64'(exp_st[k]));
      if (reg_write) begin
        rw_cnt++;
        chk("lw wb dst/m2r", 64'({reg_dst, mem_to_reg}), 64'({2'd0, 2'd1}));
      end
      @(posedge clk); #1;
    end
    chk("lw reg_write cycles", 64'(rw_cnt), 64'd1);
    chk("lw instr_cnt", 64'(instr_cnt), 64'(cnt0 + 1));

    // Illegal opcode: DECODE then TRAP, locked with no strobes until reset.
    op_i = 6'h3f; mem_ready_i = 1'b1; cnt0 = instr_cnt;
    @(negedge clk); @(posedge clk); #1;
    chk("trap decode", 64'(state_o), 64'd1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      mem_ready_i = k[0];
      chk($sformatf("trap k%0d", k),
          64'({state_o, illegal, mem_req, mem_write, ir_write, pc_en, reg_write, instr_cnt}),
          64'({4'd15, 1'b1, 5'd0, cnt0}));
    end
    rst = 1'b1; #1;
    chk("trap reset", 64'({state_o, illegal}), 64'd0);
    @(negedge clk); rst = 1'b0; mem_ready_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_instr(i, tbl[i]);

    // sw interrupted by reset while stalled in MEMWR.
    op_i = 6'h2b; mem_ready_i = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    mem_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw memwr strobes", 64'({state_o, mem_req, mem_write}), 64'({4'd5, 1'b1, 1'b1}));
    rst = 1'b1; #1;
    chk("sw async drop", 64'({mem_req, mem_write}), 64'd0);
    @(posedge clk); @(negedge clk); rst = 1'b0; #1;
    chk("sw release state/cnt", 64'({state_o, instr_cnt}), 64'd0);
    @(posedge clk); #1;
    chk("sw no reissue", 64'({state_o, mem_write}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
